// File: rtl/readout_pkg.sv
// Shared types and helpers for the pixel readout block.
// Holds the stream FSM states, width helpers and the row-select decoder.
package readout_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    typedef struct packed {
        logic [4:0] idx;
        logic       ok;
    } onehot_t;

    function automatic int col_w(input int w);
        return $clog2(w);
    endfunction

    function automatic int row_w(input int h);
        return $clog2(h);
    endfunction

    // Index of the single set bit; ok only when exactly one bit is set.
    function automatic onehot_t onehot_decode(input logic [31:0] v);
        onehot_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r.idx = 5'(i);
                n++;
            end
        end
        r.ok = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/row_line_buffer.sv
// One entry of the ping-pong line buffer: row data, row index, sof tag, full.
// Ports: wr_en/wr_* capture, clr/flush empty it, rd_col selects a pixel.
module row_line_buffer
    import readout_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int PB    = 8,
    parameter  int ROW_W = 2,
    localparam int COL_W = col_w(W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  clr,
    input  logic                  flush,
    input  logic [W-1:0][PB-1:0]  wr_data,
    input  logic [ROW_W-1:0]      wr_row,
    input  logic                  wr_sof,
    input  logic [COL_W-1:0]      rd_col,
    output logic [PB-1:0]         rd_data,
    output logic [ROW_W-1:0]      rd_row,
    output logic                  rd_sof,
    output logic                  full
);

    logic [W-1:0][PB-1:0] mem;
    logic [ROW_W-1:0]     row_q;
    logic                 sof_q;

    // A write wins over a clear so a row can land in the slot freed this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem   <= '0;
            row_q <= '0;
            sof_q <= 1'b0;
            full  <= 1'b0;
        end else if (wr_en) begin
            mem   <= wr_data;
            row_q <= wr_row;
            sof_q <= wr_sof;
            full  <= 1'b1;
        end else if (clr || flush) begin
            full  <= 1'b0;
        end
    end

    assign rd_data = mem[rd_col];
    assign rd_row  = row_q;
    assign rd_sof  = sof_q;

endmodule

// File: rtl/pixel_readout.sv
// Captures converted sensor rows into a ping-pong buffer and streams pixels.
// Ports: frame_start/row_done/row_select/data_in in, px_* valid/ready out.
module pixel_readout
    import readout_pkg::*;
#(
    parameter  int PIXEL_ARRAY_WIDTH  = 4,
    parameter  int PIXEL_ARRAY_HEIGHT = 4,
    parameter  int PIXEL_BITS         = 8,
    localparam int W     = PIXEL_ARRAY_WIDTH,
    localparam int H     = PIXEL_ARRAY_HEIGHT,
    localparam int PB    = PIXEL_BITS,
    localparam int COL_W = col_w(W),
    localparam int ROW_W = row_w(H)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 row_done,
    input  logic [H-1:0]         row_select,
    input  logic [W-1:0][PB-1:0] data_in,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic [PB-1:0]        px_data,
    output logic [COL_W-1:0]     px_col,
    output logic [ROW_W-1:0]     px_row,
    output logic                 px_sof,
    output logic                 px_eol,
    output logic                 overflow,
    output logic                 sel_error
);

    stream_state_t    state, state_nxt;
    logic             rd_ptr, wr_ptr, sof_pending;
    logic [COL_W-1:0] col;

    logic [1:0]       full, full_nxt, wr_en, clr;
    logic [PB-1:0]    b_data [2];
    logic [ROW_W-1:0] b_row  [2];
    logic [1:0]       b_sof;

    onehot_t          oh;
    logic             hs, last, free, cap, wr_sel, rd_nxt;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        row_line_buffer #(
            .W     (W),
            .PB    (PB),
            .ROW_W (ROW_W)
        ) u_buf (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[i]),
            .clr     (clr[i]),
            .flush   (frame_start),
            .wr_data (data_in),
            .wr_row  (oh.idx[ROW_W-1:0]),
            .wr_sof  (sof_pending | frame_start),
            .rd_col  (col),
            .rd_data (b_data[i]),
            .rd_row  (b_row[i]),
            .rd_sof  (b_sof[i]),
            .full    (full[i])
        );
    end

    assign hs   = px_valid & px_ready;
    assign last = hs & (col == COL_W'(W - 1));
    assign oh   = onehot_decode(32'(row_select));

    // frame_start empties both slots first, so capture always goes to slot 0.
    assign free   = frame_start | ~full[wr_ptr] | (last & (rd_ptr == wr_ptr));
    assign cap    = row_done & oh.ok & free;
    assign wr_sel = frame_start ? 1'b0 : wr_ptr;
    assign wr_en  = cap  ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    assign clr    = last ? (rd_ptr ? 2'b10 : 2'b01) : 2'b00;
    assign rd_nxt = frame_start ? 1'b0 : (rd_ptr ^ last);

    always_comb begin
        full_nxt = wr_en | (full & ~clr & {2{~frame_start}});
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (full_nxt[rd_nxt]) state_nxt = STREAM;
            end
            STREAM: begin
                if (last || frame_start)
                    state_nxt = full_nxt[rd_nxt] ? STREAM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            col         <= '0;
            sof_pending <= 1'b0;
            overflow    <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_ptr <= rd_nxt;
            if (frame_start) begin
                wr_ptr      <= cap;
                col         <= '0;
                sof_pending <= ~cap;
                overflow    <= 1'b0;
                sel_error   <= row_done & ~oh.ok;
            end else begin
                if (cap) begin
                    wr_ptr      <= ~wr_ptr;
                    sof_pending <= 1'b0;
                end
                if (row_done && !oh.ok)
                    sel_error <= 1'b1;
                if (row_done && oh.ok && !free)
                    overflow <= 1'b1;
                if (last)
                    col <= '0;
                else if (hs)
                    col <= col + COL_W'(1);
            end
        end
    end

    // Outputs are gated by valid so reset and idle both present all zeros.
    assign px_valid = (state == STREAM);
    assign px_data  = px_valid ? b_data[rd_ptr] : '0;
    assign px_row   = px_valid ? b_row[rd_ptr]  : '0;
    assign px_col   = px_valid ? col            : '0;
    assign px_sof   = px_valid & b_sof[rd_ptr] & (col == '0);
    assign px_eol   = px_valid & (col == COL_W'(W - 1));

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout with W=4, H=4, 8-bit pixels.
// Drives at posedge+1, samples at negedge, reports one summary line.
module tb_pixel_readout;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            frame_start = 1'b0;
    logic            row_done = 1'b0;
    logic [3:0]      row_select = '0;
    logic [3:0][7:0] data_in = '0;
    logic            px_valid;
    logic            px_ready = 1'b0;
    logic [7:0]      px_data;
    logic [1:0]      px_col;
    logic [1:0]      px_row;
    logic            px_sof;
    logic            px_eol;
    logic            overflow;
    logic            sel_error;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_readout #(
        .PIXEL_ARRAY_WIDTH  (4),
        .PIXEL_ARRAY_HEIGHT (4),
        .PIXEL_BITS         (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .row_done    (row_done),
        .row_select  (row_select),
        .data_in     (data_in),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_data     (px_data),
        .px_col      (px_col),
        .px_row      (px_row),
        .px_sof      (px_sof),
        .px_eol      (px_eol),
        .overflow    (overflow),
        .sel_error   (sel_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic row(input logic [3:0] sel, input logic [3:0][7:0] d);
        row_done   = 1'b1;
        row_select = sel;
        data_in    = d;
        step();
        row_done   = 1'b0;
    endtask

    // Row r, column c carries (r+1)*16 + c.
    function automatic logic [3:0][7:0] mk(input int r);
        logic [3:0][7:0] v;
        for (int c = 0; c < 4; c++) v[c] = 8'((r + 1) * 16 + c);
        return v;
    endfunction

    task automatic exp_px(input string tag, input int d, input int c,
                          input int r, input int sof, input int eol);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(px_valid), 1);
        chk({tag, ".data"},  32'(px_data),  32'(d));
        chk({tag, ".col"},   32'(px_col),   32'(c));
        chk({tag, ".row"},   32'(px_row),   32'(r));
        chk({tag, ".sof"},   32'(px_sof),   32'(sof));
        chk({tag, ".eol"},   32'(px_eol),   32'(eol));
    endtask

    task automatic exp_idle(input string tag);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(px_valid), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(px_valid),  0);
        chk({tag, ".data"},  32'(px_data),   0);
        chk({tag, ".col"},   32'(px_col),    0);
        chk({tag, ".row"},   32'(px_row),    0);
        chk({tag, ".sof"},   32'(px_sof),    0);
        chk({tag, ".eol"},   32'(px_eol),    0);
        chk({tag, ".ovf"},   32'(overflow),  0);
        chk({tag, ".sel"},   32'(sel_error), 0);
    endtask

    task automatic basic(input string tag);
        logic [3:0][7:0] d;
        d = {8'h40, 8'h30, 8'h20, 8'h10};
        px_ready = 1'b1;
        fs();
        row(4'b0001, d);
        for (int c = 0; c < 4; c++) begin
            exp_px($sformatf("%s.c%0d", tag, c), 16 * (c + 1), c, 0,
                   (c == 0) ? 1 : 0, (c == 3) ? 1 : 0);
            step();
        end
        exp_idle({tag, ".end"});
    endtask

    initial begin
        #3;
        chk_zero("reset");
        step();
        reset = 1'b1;
        step();

        basic("basic");

        // Backpressure at column 1.
        px_ready = 1'b1;
        fs();
        row(4'b0001, {8'h40, 8'h30, 8'h20, 8'h10});
        exp_px("bp.c0", 8'h10, 0, 0, 1, 0);
        step();
        px_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_px($sformatf("bp.hold%0d", k), 8'h20, 1, 0, 0, 0);
            step();
        end
        px_ready = 1'b1;
        exp_px("bp.c1", 8'h20, 1, 0, 0, 0);
        step();
        exp_px("bp.c2", 8'h30, 2, 0, 0, 0);
        step();
        exp_px("bp.c3", 8'h40, 3, 0, 0, 1);
        step();
        exp_idle("bp.end");

        // Ping-pong with overflow on the third row.
        fs();
        px_ready = 1'b0;
        row(4'b0001, mk(0));
        row(4'b0010, mk(1));
        row(4'b0100, mk(2));
        @(negedge clk);
        chk("pp.ovf", 32'(overflow), 1);
        step();
        px_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_px($sformatf("pp.k%0d", k), (k / 4 + 1) * 16 + k % 4,
                   k % 4, k / 4, (k == 0) ? 1 : 0, (k % 4 == 3) ? 1 : 0);
            step();
        end
        exp_idle("pp.end");
        chk("pp.ovf_sticky", 32'(overflow), 1);

        // Row arrives on the eol handshake while both slots are full.
        fs();
        px_ready = 1'b0;
        row(4'b0001, mk(0));
        row(4'b0010, mk(1));
        px_ready = 1'b1;
        step();
        step();
        step();
        row_done   = 1'b1;
        row_select = 4'b1000;
        data_in    = mk(3);
        exp_px("fsc.c3", 8'h13, 3, 0, 0, 1);
        step();
        row_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_px($sformatf("fsc.k%0d", k),
                   ((k < 4) ? 2 : 4) * 16 + k % 4, k % 4,
                   (k < 4) ? 1 : 3, 0, (k % 4 == 3) ? 1 : 0);
            step();
        end
        exp_idle("fsc.end");
        chk("fsc.ovf", 32'(overflow), 0);

        // Select errors, then cleared by frame_start.
        fs();
        row(4'b0110, mk(1));
        @(negedge clk);
        chk("sel.err", 32'(sel_error), 1);
        chk("sel.valid", 32'(px_valid), 0);
        step();
        exp_idle("sel.idle");
        fs();
        @(negedge clk);
        chk("sel.clr", 32'(sel_error), 0);
        step();
        row(4'b0000, mk(1));
        @(negedge clk);
        chk("sel.zero", 32'(sel_error), 1);
        chk("sel.zero_valid", 32'(px_valid), 0);
        step();

        // Asynchronous reset mid-row.
        px_ready = 1'b1;
        fs();
        row(4'b0001, mk(0));
        step();
        step();
        exp_px("rst.c2", 8'h12, 2, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("rst.async");
        step();
        reset = 1'b1;
        exp_idle("rst.after");
        step();
        basic("rst.basic");

        // Flush by frame_start mid-row.
        px_ready = 1'b1;
        fs();
        row(4'b0010, mk(1));
        step();
        step();
        exp_px("fl.c2", 8'h22, 2, 1, 0, 0);
        fs();
        exp_idle("fl.v0");
        step();
        exp_idle("fl.v1");
        step();
        exp_idle("fl.v2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
